// File: rtl/pe_south_drain.sv
// South-edge drain: captures the flagged lanes of the upstream tile's south bus into a FIFO
// and presents them as a single valid/ready payload stream; words arriving at a full FIFO are dropped and counted.
module pe_south_drain #(
    parameter int NORTH_WIDTH        = 260,
    parameter int LANE_WIDTH         = 130,
    parameter int NUM_BRAM_ADDR_BITS = 7,
    parameter int DROP_CNT_WIDTH     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ap_start,
    input  logic [NORTH_WIDTH-1:0]        in_from_north,
    output logic [LANE_WIDTH-2:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_BRAM_ADDR_BITS:0]   fifo_count,
    output logic                          overflow,
    output logic [DROP_CNT_WIDTH-1:0]     drop_count,
    input  logic                          clear_status
);

    localparam int AW    = NUM_BRAM_ADDR_BITS;
    localparam int PW    = LANE_WIDTH - 1;
    localparam int DW    = DROP_CNT_WIDTH;
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);
    localparam logic [AW:0] TWO_C   = (AW+1)'(2);

    logic [PW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic [DW-1:0] r_drop_cnt;

    logic          w_v0;
    logic          w_v1;
    logic [PW-1:0] w_p0;
    logic [PW-1:0] w_p1;
    logic [AW:0]   w_free;
    logic          w_acc0;
    logic          w_acc1;
    logic          w_drop0;
    logic          w_drop1;
    logic [1:0]    w_n_push;
    logic [1:0]    w_n_drop;
    logic          w_pop;
    logic [AW-1:0] w_wr1;
    logic [AW:0]   w_count_next;
    logic [DW-1:0] w_drop_base;
    logic [DW:0]   w_drop_sum;
    logic [DW-1:0] w_drop_next;
    logic          w_ovf_next;

    // Input is only meaningful on ap_start cycles; the tile holds its outputs otherwise.
    assign w_v0 = ap_start & in_from_north[LANE_WIDTH-1];
    assign w_v1 = ap_start & in_from_north[2*LANE_WIDTH-1];
    assign w_p0 = in_from_north[PW-1:0];
    assign w_p1 = in_from_north[LANE_WIDTH+PW-1:LANE_WIDTH];

    // Space is judged on the pre-edge count; a same-edge pop never frees room for pushes.
    assign w_free  = DEPTH_C - r_count;
    assign w_acc0  = w_v0 && (w_free != '0);
    assign w_acc1  = w_v1 && ((w_free >= TWO_C) || ((w_free == ONE_C) && !w_v0));
    assign w_drop0 = w_v0 & ~w_acc0;
    assign w_drop1 = w_v1 & ~w_acc1;

    assign w_n_push = {1'b0, w_acc0} + {1'b0, w_acc1};
    assign w_n_drop = {1'b0, w_drop0} + {1'b0, w_drop1};
    assign w_pop    = out_valid & out_ready;
    assign w_wr1    = r_wr_ptr + AW'(w_acc0);

    assign w_count_next = r_count + (AW+1)'(w_n_push) - (AW+1)'(w_pop);

    // A drop on a clearing edge overrides the clear.
    assign w_drop_base = clear_status ? '0 : r_drop_cnt;
    assign w_drop_sum  = {1'b0, w_drop_base} + (DW+1)'(w_n_drop);
    assign w_drop_next = w_drop_sum[DW] ? {DW{1'b1}} : w_drop_sum[DW-1:0];
    assign w_ovf_next  = (clear_status ? 1'b0 : r_overflow) | (w_n_drop != 2'd0);

    always_ff @(posedge clk) begin
        if (w_acc0) begin
            r_mem[r_wr_ptr] <= w_p0;
        end
        if (w_acc1) begin
            r_mem[w_wr1] <= w_p1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + AW'(w_n_push);
            r_rd_ptr   <= r_rd_ptr + AW'(w_pop);
            r_count    <= w_count_next;
            r_overflow <= w_ovf_next;
            r_drop_cnt <= w_drop_next;
        end
    end

    assign out_valid  = (r_count != '0);
    assign out_data   = out_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_cnt;

endmodule

// File: doc/pe_south_drain.md
Name: pe_south_drain

Overview:
- Downstream neighbour of a mesh pass-through tile; consumes the tile's registered south output bus.
- That bus carries two flagged lanes per cycle. This block extracts the valid lanes and buffers them in a FIFO.
- It emits a single valid/ready stream of payload words toward the south-edge sink.
- There is no upstream backpressure, so words that find the FIFO full are dropped and counted.

Parameters:
- NORTH_WIDTH, 260: width of input bus; must equal 2*LANE_WIDTH.
- LANE_WIDTH, 130: lane width; MSB is lane-valid flag, low LANE_WIDTH-1 bits are payload.
- NUM_BRAM_ADDR_BITS, 7: FIFO depth = 2**NUM_BRAM_ADDR_BITS (default 128).
- DROP_CNT_WIDTH, 16: width of dropped-word counter.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- ap_start  input  1  capture enable; same signal that advances the upstream tile.
- in_from_north  input  NORTH_WIDTH  = {lane1, lane0}; lane k = bits [(k+1)*LANE_WIDTH-1 : k*LANE_WIDTH].
- out_data  output  LANE_WIDTH-1  payload at FIFO head.
- out_valid  output  1  head word available.
- out_ready  input  1  sink accepts head word.
- fifo_count  output  NUM_BRAM_ADDR_BITS+1  words currently stored, 0..DEPTH.
- overflow  output  1  sticky; set by any drop.
- drop_count  output  DROP_CNT_WIDTH  saturating count of dropped words.
- clear_status  input  1  synchronous clear of overflow and drop_count.

Behaviour:
- Reset (reset=0, asynchronous): rd/wr pointers=0, fifo_count=0, out_valid=0, out_data=0, overflow=0, drop_count=0. FIFO contents are discarded; reset mid-stream loses all buffered words. Memory array is not cleared.
- Capture: on a rising edge with ap_start=1, each lane whose flag bit is 1 is a push candidate. With ap_start=0 the input is ignored entirely, because the tile holds its outputs and they must not be re-captured.
- Ordering: when both lanes are valid, lane0 is written before lane1 (lane0 at wr_ptr, lane1 at wr_ptr+1).
- Free space: free = DEPTH - fifo_count sampled before the edge. A pop on the same edge does NOT create space for that edge's pushes.
  - free>=2: all candidates accepted.
  - free==1: lane0 accepted if valid. lane1 is accepted only if lane0 is invalid; otherwise it is dropped.
  - free==0: all candidates dropped.
- Drops: drop_count += number dropped this edge (0..2), saturating at all-ones. overflow is set on any drop.
- clear_status=1 zeroes overflow and drop_count. If a drop occurs on the same edge, the drop wins: overflow=1 and drop_count = number dropped that edge.
- Output:
  - out_valid = (fifo_count != 0).
  - out_data = mem[rd_ptr] when out_valid=1, otherwise 0.
  - Pop occurs when out_valid && out_ready at the rising edge.
  - out_data and out_valid are held stable while out_ready=0.
- Latency: a word pushed at edge N is visible (out_valid=1) from just after edge N. Throughput is at most 1 word/cycle out and 2 words/cycle in.
- Count update: fifo_count_next = fifo_count + pushes - pop. Simultaneous push and pop on a full FIFO is legal; the pushes are evaluated against the pre-pop free space.
- Pointers wrap modulo DEPTH with no special-case at wrap.

Test Plan:
- Reset release, ap_start=1, lane0={1,payload 0x1}, lane1={1,payload 0x2}, out_ready=1 -> out_data 0x1 then 0x2 on consecutive cycles; fifo_count peaks at 2; overflow=0.
- ap_start=0 for 5 cycles with both lane flags=1 -> fifo_count stays 0, out_valid=0.
- out_ready=0, 64 cycles of dual-valid input (128 words) -> fifo_count=128. Next dual-valid cycle -> drop_count=2, overflow=1.
- Same test with 127 words stored, then dual-valid cycle -> lane0 stored (count=128), lane1 dropped (drop_count=1). Drain with out_ready=1 -> words emerge in push order, including across pointer wrap.
- Drop on the same cycle as clear_status=1 -> overflow=1, drop_count=number dropped. Clear with no drop -> overflow=0, drop_count=0.
- Assert reset=0 asynchronously mid-drain with 10 words stored -> out_valid falls immediately, fifo_count=0. After release no stale word appears.
